// File: rtl/ds18b20_pkg.sv
// Shared definitions for the DS18B20 measurement sequencer.
//   - 1-wire byte-master operation encodings (ow_op)
//   - DS18B20 command bytes and the power-on scratchpad temperature
//   - sequencer state enum plus helpers that map an operation state to its
//     bus operation, command byte and successor state
package ds18b20_pkg;

  localparam logic [1:0] OW_OP_RESET = 2'd0;
  localparam logic [1:0] OW_OP_WRITE = 2'd1;
  localparam logic [1:0] OW_OP_READ  = 2'd2;

  localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
  localparam logic [7:0] CMD_CONVERT_T = 8'h44;
  localparam logic [7:0] CMD_READ_SP   = 8'hBE;

  // Scratchpad temperature after power-up: +85.0 C
  localparam logic [15:0] POR_TEMP = 16'h0550;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST1,
    ST_SKIP1,
    ST_CONVT,
    ST_WAIT,
    ST_RST2,
    ST_SKIP2,
    ST_RDSP,
    ST_RD_LSB,
    ST_RD_MSB,
    ST_LATCH
  } state_e;

  // Bus operation issued by an operation state
  function automatic logic [1:0] op_of(state_e s);
    case (s)
      ST_RST1, ST_RST2:     return OW_OP_RESET;
      ST_RD_LSB, ST_RD_MSB: return OW_OP_READ;
      default:              return OW_OP_WRITE;
    endcase
  endfunction

  // Command byte for WRITE states; zero for RESET/READ
  function automatic logic [7:0] cmd_of(state_e s);
    case (s)
      ST_SKIP1, ST_SKIP2: return CMD_SKIP_ROM;
      ST_CONVT:           return CMD_CONVERT_T;
      ST_RDSP:            return CMD_READ_SP;
      default:            return 8'h00;
    endcase
  endfunction

  // State entered after a successful acknowledge
  function automatic state_e next_of(state_e s);
    case (s)
      ST_RST1:   return ST_SKIP1;
      ST_SKIP1:  return ST_CONVT;
      ST_CONVT:  return ST_WAIT;
      ST_RST2:   return ST_SKIP2;
      ST_SKIP2:  return ST_RDSP;
      ST_RDSP:   return ST_RD_LSB;
      ST_RD_LSB: return ST_RD_MSB;
      ST_RD_MSB: return ST_LATCH;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ds18b20_ms_timer.sv
// Millisecond time base for the sequencer.
//   clk  in             system clock
//   rst  in             synchronous reset, active-high
//   clr  in  [N-1:0]    per-counter synchronous clear (wins over a tick)
//   cnt  out [N-1:0][W] saturating millisecond counters
// A free-running prescaler produces one tick every DIV cycles; every counter
// shares that tick, so all millisecond measurements carry the same +/-1 tick
// phase uncertainty relative to their clear.
module ds18b20_ms_timer #(
  parameter int unsigned DIV = 12_000,
  parameter int unsigned N   = 2,
  parameter int unsigned W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        clr,
  output logic [N-1:0][W-1:0] cnt
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (pre == PRE_MAX) begin
      pre  <= '0;
      tick <= 1'b1;
    end else begin
      pre  <= pre + 1'b1;
      tick <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cnt
      // Saturate so a long idle period can never wrap back below a threshold
      always_ff @(posedge clk) begin
        if (rst || clr[gi]) begin
          cnt[gi] <= '0;
        end else if (tick && (cnt[gi] != {W{1'b1}})) begin
          cnt[gi] <= cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ds18b20_sequencer.sv
// DS18B20 measurement scheduler driving a 1-wire byte master.
//   clk, rst                      clock, synchronous active-high reset
//   enable                        run periodic measurements (sampled in IDLE)
//   ow_req/ow_op/ow_wdata         request to byte master, held until ow_ack
//   ow_ack/ow_rdata/ow_presence   completion pulse and its result
//   data_out/data_valid           latest raw {MSB,LSB} word and update pulse
//   err_nopres/err_timeout        sticky faults, cleared by the next good word
// Sequence: reset, Skip-ROM, Convert-T, conversion wait, reset, Skip-ROM,
// Read-Scratchpad, read LSB, read MSB, latch.
module ds18b20_sequencer
  import ds18b20_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12_000_000,
  parameter int unsigned CONV_MS   = 750,
  parameter int unsigned PERIOD_MS = 1000,
  parameter int unsigned ACK_TO_MS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        ow_req,
  output logic [1:0]  ow_op,
  output logic [7:0]  ow_wdata,
  input  logic        ow_ack,
  input  logic [7:0]  ow_rdata,
  input  logic        ow_presence,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        err_nopres,
  output logic        err_timeout
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] PERIOD_T = CW'(PERIOD_MS);
  localparam logic [CW-1:0] CONV_T   = CW'(CONV_MS);
  localparam logic [CW-1:0] ACK_TO_T = CW'(ACK_TO_MS);

  state_e                 state;
  logic                   first_run;
  logic [7:0]             lsb_q;
  logic [7:0]             msb_q;
  logic [1:0]             clr;
  logic [1:0][CW-1:0]     cnt;
  logic [CW-1:0]          period_cnt;
  logic [CW-1:0]          op_cnt;
  logic                   start;
  logic                   issue;
  logic                   is_op;

  // cnt[0]: start-to-start period; cnt[1]: ack timeout / conversion wait
  ds18b20_ms_timer #(
    .DIV (CLK_HZ / 1000),
    .N   (2),
    .W   (CW)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .cnt (cnt)
  );

  assign period_cnt = cnt[0];
  assign op_cnt     = cnt[1];

  always_comb begin
    is_op = (state != ST_IDLE) && (state != ST_WAIT) && (state != ST_LATCH);
    // The very first measurement after reset does not wait out a period
    start = (state == ST_IDLE) && enable && (first_run || (period_cnt >= PERIOD_T));
    // In an operation state ow_req is low only on the entry cycle; that one
    // cycle gap guarantees a request never rises in the same cycle it fell
    issue = is_op && !ow_req;
    clr   = {issue || ((state == ST_CONVT) && ow_req && ow_ack), start};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      first_run   <= 1'b1;
      ow_req      <= 1'b0;
      ow_op       <= OW_OP_RESET;
      ow_wdata    <= 8'h00;
      lsb_q       <= 8'h00;
      msb_q       <= 8'h00;
      data_out    <= POR_TEMP;
      data_valid  <= 1'b0;
      err_nopres  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RST1;
            first_run <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (op_cnt >= CONV_T) state <= ST_RST2;
        end
        ST_LATCH: begin
          data_out    <= {msb_q, lsb_q};
          data_valid  <= 1'b1;
          err_nopres  <= 1'b0;
          err_timeout <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          if (issue) begin
            ow_req   <= 1'b1;
            ow_op    <= op_of(state);
            ow_wdata <= cmd_of(state);
          end else if (ow_ack) begin
            // ow_req is high here, so this acknowledge belongs to us
            ow_req <= 1'b0;
            if (state == ST_RD_LSB) lsb_q <= ow_rdata;
            if (state == ST_RD_MSB) msb_q <= ow_rdata;
            if (((state == ST_RST1) || (state == ST_RST2)) && !ow_presence) begin
              err_nopres <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              state <= next_of(state);
            end
          end else if (op_cnt >= ACK_TO_T) begin
            err_timeout <= 1'b1;
            ow_req      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // The period must leave room for the conversion plus the bus traffic
  period_ok: assert property (@(posedge clk) disable iff (rst) PERIOD_MS >= CONV_MS + 10);

endmodule

// File: tb/tb_ds18b20_sequencer.sv
// Self-checking bench for ds18b20_sequencer with a byte-master model that
// acknowledges every request after 100 cycles. Written bytes, read bytes and
// expected data words travel through scoreboard queues filled when a run is
// set up and drained when the DUT issues requests or pulses data_valid.
module tb_ds18b20_sequencer;
  import ds18b20_pkg::*;

  localparam int unsigned CLK_HZ    = 100_000;
  localparam int unsigned CONV_MS   = 2;
  localparam int unsigned PERIOD_MS = 12;
  localparam int unsigned ACK_TO_MS = 5;
  localparam int DIV     = CLK_HZ / 1000;
  localparam int ACK_DLY = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        ow_req;
  logic [1:0]  ow_op;
  logic [7:0]  ow_wdata;
  logic        ow_ack = 1'b0;
  logic [7:0]  ow_rdata = 8'h00;
  logic        ow_presence = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        err_nopres;
  logic        err_timeout;

  ds18b20_sequencer #(
    .CLK_HZ    (CLK_HZ),
    .CONV_MS   (CONV_MS),
    .PERIOD_MS (PERIOD_MS),
    .ACK_TO_MS (ACK_TO_MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .ow_req      (ow_req),
    .ow_op       (ow_op),
    .ow_wdata    (ow_wdata),
    .ow_ack      (ow_ack),
    .ow_rdata    (ow_rdata),
    .ow_presence (ow_presence),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .err_nopres  (err_nopres),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards
  logic [7:0]  wr_q[$];
  logic [7:0]  rd_q[$];
  logic [15:0] dv_q[$];

  // Byte-master behaviour and observations
  logic bfm_pres = 1'b1;
  logic bfm_hang = 1'b0;
  int rst_starts = 0, rst_start_cyc = 0, read_starts = 0;
  int convt_acks = 0, convt_ack_cyc = 0, w44_start_cyc = 0;
  int dv_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Byte-master model
  initial begin : bfm
    logic       busy;
    int         cnt;
    logic [1:0] op;
    logic [7:0] wd;
    busy = 1'b0;
    cnt = 0;
    op = 2'd0;
    wd = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      ow_ack = 1'b0;
      if (rst) begin
        busy = 1'b0;
        continue;
      end
      if (busy && !ow_req) busy = 1'b0;
      if (ow_req && !busy) begin
        busy = 1'b1;
        cnt = 0;
        op = ow_op;
        wd = ow_wdata;
        if (op == OW_OP_RESET) begin
          rst_starts++;
          rst_start_cyc = cyc;
        end
        if (op == OW_OP_READ) read_starts++;
        if (op == OW_OP_WRITE) begin
          if (wd == CMD_CONVERT_T) w44_start_cyc = cyc;
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write_unexpected: got %0h expected none", wd);
          end else begin
            check("write_byte", {24'h0, wd}, {24'h0, wr_q.pop_front()});
          end
        end
      end
      if (busy) begin
        cnt++;
        if (cnt >= ACK_DLY && !(bfm_hang && op == OW_OP_WRITE && wd == CMD_CONVERT_T)) begin
          ow_ack = 1'b1;
          ow_presence = bfm_pres;
          if (op == OW_OP_READ) ow_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
          if (op == OW_OP_WRITE && wd == CMD_CONVERT_T) begin
            convt_acks++;
            convt_ack_cyc = cyc;
          end
          busy = 1'b0;
        end
      end
    end
  end

  // data_valid monitor
  initial begin : mon
    logic prev_dv;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid) begin
        dv_cnt++;
        if (prev_dv) begin
          checks++;
          errors++;
          $display("FAIL dv_width: got 2+ cycles expected 1");
        end
        if (dv_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dv_unexpected: got %0h expected none", data_out);
        end else begin
          check("data_out_dv", {16'h0, data_out}, {16'h0, dv_q.pop_front()});
        end
      end
      prev_dv = data_valid;
    end
  end

  typedef struct {
    logic        pres;
    logic        hang;
    logic [7:0]  lsb;
    logic [7:0]  msb;
    logic [15:0] exp_data;
    int          exp_dv;
    logic        exp_nopres;
    logic        exp_timeout;
  } vec_t;

  vec_t vecs[5];

  task automatic push_sequence(input logic pres, input logic hang, input logic [7:0] lsb,
                               input logic [7:0] msb);
    if (pres) begin
      wr_q.push_back(CMD_SKIP_ROM);
      wr_q.push_back(CMD_CONVERT_T);
      if (!hang) begin
        wr_q.push_back(CMD_SKIP_ROM);
        wr_q.push_back(CMD_READ_SP);
        rd_q.push_back(lsb);
        rd_q.push_back(msb);
      end
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!ow_req && n < PERIOD_MS * DIV + 300) begin
      @(negedge clk);
      n++;
    end
    if (!ow_req) check(name, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   dv0, n, to_cyc;
    logic np0, to0, done;
    bfm_pres = v.pres;
    bfm_hang = v.hang;
    wr_q.delete();
    rd_q.delete();
    push_sequence(v.pres, v.hang, v.lsb, v.msb);
    if (v.exp_dv != 0) dv_q.push_back(v.exp_data);
    dv0 = dv_cnt;
    np0 = err_nopres;
    to0 = err_timeout;
    to_cyc = 0;
    enable = 1'b1;
    wait_req("run_start");
    enable = 1'b0;
    done = 1'b0;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      done = (dv_cnt != dv0) || (err_nopres && !np0) || (err_timeout && !to0);
    end
    to_cyc = cyc;
    if (!done) check("run_end", 32'd0, 32'd1);
    if (v.hang) check_range("timeout_latency", to_cyc - w44_start_cyc,
                            (ACK_TO_MS - 1) * DIV, ACK_TO_MS * DIV + 3);
    repeat (3) @(negedge clk);
    $display("vec %0d: data_out=%h nopres=%0b timeout=%0b dv=%0d", idx, data_out,
             err_nopres, err_timeout, dv_cnt - dv0);
    check("vec_data_out", {16'h0, data_out}, {16'h0, v.exp_data});
    check("vec_nopres", {31'h0, err_nopres}, {31'h0, v.exp_nopres});
    check("vec_timeout", {31'h0, err_timeout}, {31'h0, v.exp_timeout});
    check("vec_req_low", {31'h0, ow_req}, 32'd0);
    check("vec_dv_count", dv_cnt - dv0, v.exp_dv);
    check("vec_writes_done", wr_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    $display("%s: data_out=%h req=%0b dv=%0b nopres=%0b timeout=%0b", tag, data_out, ow_req,
             data_valid, err_nopres, err_timeout);
    check({tag, "_data_out"}, {16'h0, data_out}, {16'h0, POR_TEMP});
    check({tag, "_req"}, {31'h0, ow_req}, 32'd0);
    check({tag, "_dv"}, {31'h0, data_valid}, 32'd0);
    check({tag, "_errs"}, {30'h0, err_nopres, err_timeout}, 32'd0);
  endtask

  // Hold rst across one edge in the middle of a run, then verify reset values
  task automatic mid_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values(tag);
    enable = 1'b0;
    wr_q.delete();
    rd_q.delete();
    dv_q.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0, s1, gap, n, base;
    vecs[0] = '{1'b1, 1'b0, 8'h91, 8'h01, 16'h0191, 1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0191, 0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'h00, 8'h00, 16'h0191, 0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h5E, 8'hFF, 16'hFF5E, 1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h90, 8'hFC, 16'hFC90, 1, 1'b0, 1'b0};

    repeat (4) @(negedge clk);
    check_reset_values("reset");
    check("reset_op", {30'h0, ow_op}, 32'd0);
    check("reset_wdata", {24'h0, ow_wdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two back-to-back measurements with enable held: conversion wait and period
    bfm_pres = 1'b1;
    bfm_hang = 1'b0;
    push_sequence(1'b1, 1'b0, 8'h91, 8'h01);
    push_sequence(1'b1, 1'b0, 8'hA2, 8'h00);
    dv_q.push_back(16'h0191);
    dv_q.push_back(16'h00A2);
    enable = 1'b1;
    wait_req("first_start");
    s0 = rst_start_cyc;
    n = 0;
    while (dv_cnt < 1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("first_dv", dv_cnt, 32'd1);
    gap = rst_start_cyc - convt_ack_cyc;
    $display("conv gap: %0d cycles", gap);
    check_range("conv_wait", gap, (CONV_MS - 1) * DIV, CONV_MS * DIV + 4);
    n = 0;
    while (rst_starts < 3 && n < PERIOD_MS * DIV + 300) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    s1 = rst_start_cyc;
    $display("period: %0d cycles", s1 - s0);
    check_range("period", s1 - s0, (PERIOD_MS - 1) * DIV, PERIOD_MS * DIV + 2);
    n = 0;
    while (dv_cnt < 2 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("second_dv", dv_cnt, 32'd2);
    check("second_data_out", {16'h0, data_out}, 32'h00A2);
    check("second_writes_done", wr_q.size(), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Reset while waiting for the conversion
    bfm_pres = 1'b1;
    bfm_hang = 1'b0;
    push_sequence(1'b1, 1'b0, 8'h11, 8'h22);
    base = convt_acks;
    enable = 1'b1;
    n = 0;
    while (convt_acks == base && n < PERIOD_MS * DIV + 1000) begin
      @(negedge clk);
      n++;
    end
    if (convt_acks == base) check("reach_wait", 32'd0, 32'd1);
    repeat (20) @(negedge clk);
    mid_reset("rst_wait");
    run_vec('{1'b1, 1'b0, 8'h34, 8'h12, 16'h1234, 1, 1'b0, 1'b0}, 5);

    // Reset during the MSB read
    push_sequence(1'b1, 1'b0, 8'h33, 8'h44);
    base = read_starts;
    enable = 1'b1;
    n = 0;
    while (read_starts < base + 2 && n < PERIOD_MS * DIV + 2000) begin
      @(negedge clk);
      n++;
    end
    if (read_starts < base + 2) check("reach_rd_msb", 32'd0, 32'd1);
    repeat (10) @(negedge clk);
    mid_reset("rst_rdmsb");
    run_vec('{1'b1, 1'b0, 8'h78, 8'h01, 16'h0178, 1, 1'b0, 1'b0}, 6);

    check("dv_queue_empty", dv_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
